// File: rtl/bike_pkg.sv
// Shared definitions for the bike computer datapath: divider arbiter states,
// the all-ones error quotient and the requester indices.
package bike_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Quotient returned on timeout or divide-by-zero; slice to the datapath width.
  localparam logic [63:0] DIV_ERR_RES = '1;

  localparam int REQ_SPEED = 0;
  localparam int REQ_AVG   = 1;

endpackage

// File: rtl/div_req_slot.sv
// One request slot of the divider arbiter: holds a pending flag with the
// captured operands and a sticky overrun flag for requests that arrive
// while the slot is still occupied.
module div_req_slot
  import bike_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req,
  input  logic             clear,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             pending,
  output logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] divisor,
  output logic             overrun
);

  // Capture a request into a free slot; a request arriving in the completing cycle wins over the clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending  <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      overrun  <= 1'b0;
    end else if (req && (!pending || clear)) begin
      pending  <= 1'b1;
      dividend <= req_dividend;
      divisor  <= req_divisor;
    end else begin
      if (req) begin
        overrun <= 1'b1;
      end
      if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between the speed and
// average-speed requesters. Launches the divider, waits for ready (with a
// timeout), and hands the quotient back with a one-cycle per-requester valid.
module div_arbiter
  import bike_pkg::*;
#(
  parameter int WIDTH   = 26,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             req0,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             div_en,
  output logic             div_select,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_res,
  output logic [WIDTH-1:0] res,
  output logic             valid0,
  output logic             valid1,
  output logic             err,
  output logic [1:0]       overrun
);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [1:0]       pending;
  logic [WIDTH-1:0] held_dividend0;
  logic [WIDTH-1:0] held_divisor0;
  logic [WIDTH-1:0] held_dividend1;
  logic [WIDTH-1:0] held_divisor1;
  logic             last_grant;
  logic [TO_W-1:0]  timeout_cnt;
  logic             winner;
  logic [WIDTH-1:0] win_dividend;
  logic [WIDTH-1:0] win_divisor;
  logic             start_grant;
  logic             timeout_hit;
  logic             unused_busy;

  // The divider's busy flag is informational; the FSM relies on ready and the timeout.
  assign unused_busy = div_busy;

  div_req_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req0),
    .clear        (valid0),
    .req_dividend (dividend0),
    .req_divisor  (divisor0),
    .pending      (pending[0]),
    .dividend     (held_dividend0),
    .divisor      (held_divisor0),
    .overrun      (overrun[0])
  );

  div_req_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req1),
    .clear        (valid1),
    .req_dividend (dividend1),
    .req_divisor  (divisor1),
    .pending      (pending[1]),
    .dividend     (held_dividend1),
    .divisor      (held_divisor1),
    .overrun      (overrun[1])
  );

  // Pick the winner: alternate on a tie, otherwise the only pending requester.
  always_comb begin
    winner = 1'b0;
    if (pending == 2'b11) begin
      winner = ~last_grant;
    end else if (pending[1]) begin
      winner = 1'b1;
    end
  end

  assign win_dividend = winner ? held_dividend1 : held_dividend0;
  assign win_divisor  = winner ? held_divisor1  : held_divisor0;
  assign start_grant  = (state == IDLE) && en && (pending != 2'b00);
  assign timeout_hit  = (timeout_cnt == TO_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the one-cycle divider start and result valids.
  always_comb begin
    next_state = state;
    div_en     = 1'b0;
    valid0     = 1'b0;
    valid1     = 1'b0;
    case (state)
      IDLE: begin
        if (start_grant) begin
          next_state = (win_divisor == '0) ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        div_en     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (div_ready || timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        valid0     = (div_select == 1'(REQ_SPEED));
        valid1     = (div_select == 1'(REQ_AVG));
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch the grant and operands, run the timeout, and hold the result until the next completion.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_select   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      res          <= '0;
      err          <= 1'b0;
      last_grant   <= 1'b1;
      timeout_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_grant) begin
            div_select   <= winner;
            div_dividend <= win_dividend;
            div_divisor  <= win_divisor;
            if (win_divisor == '0) begin
              res <= DIV_ERR_RES[WIDTH-1:0];
              err <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          timeout_cnt <= '0;
        end
        WAIT: begin
          if (div_ready) begin
            res <= div_res;
            err <= 1'b0;
          end else if (timeout_hit) begin
            res <= DIV_ERR_RES[WIDTH-1:0];
            err <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end
        DONE: begin
          last_grant <= div_select;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural iterative divider model.
module tb_div_arbiter;

  localparam int WIDTH   = 26;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;

  typedef struct {
    logic             sel;
    logic [WIDTH-1:0] res;
    logic             err;
    int               start;
    int               lat;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b1;
  logic             req0 = 1'b0;
  logic [WIDTH-1:0] dividend0 = '0;
  logic [WIDTH-1:0] divisor0 = '0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] dividend1 = '0;
  logic [WIDTH-1:0] divisor1 = '0;
  logic             div_en;
  logic             div_select;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy = 1'b0;
  logic             div_ready = 1'b0;
  logic [WIDTH-1:0] div_res = '0;
  logic [WIDTH-1:0] res;
  logic             valid0;
  logic             valid1;
  logic             err;
  logic [1:0]       overrun;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;
  int   enCount = 0;
  int   enCyc = 0;
  logic enSel = 1'b0;
  exp_t sb[$];
  exp_t e;

  int               modelDelay = 26;
  bit               modelHang = 1'b0;
  bit               modelActive = 1'b0;
  int               modelRem = 0;
  logic [WIDTH-1:0] modelQ = '0;

  div_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .en           (en),
    .req0         (req0),
    .dividend0    (dividend0),
    .divisor0     (divisor0),
    .req1         (req1),
    .dividend1    (dividend1),
    .divisor1     (divisor1),
    .div_en       (div_en),
    .div_select   (div_select),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_ready    (div_ready),
    .div_res      (div_res),
    .res          (res),
    .valid0       (valid0),
    .valid1       (valid1),
    .err          (err),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  // Cycle counter used to measure latencies.
  always @(posedge clock) cyc <= cyc + 1;

  // Divider model: ready pulses modelDelay cycles after the start, unless hung.
  always @(posedge clock) begin
    div_ready <= 1'b0;
    if (div_en) begin
      modelActive <= 1'b1;
      modelRem    <= modelDelay - 1;
      modelQ      <= (div_divisor != '0) ? div_dividend / div_divisor : '1;
      div_busy    <= 1'b1;
    end else if (modelActive) begin
      if (modelRem <= 1) begin
        if (!modelHang) begin
          div_ready   <= 1'b1;
          div_res     <= modelQ;
          modelActive <= 1'b0;
          div_busy    <= 1'b0;
        end
      end else begin
        modelRem <= modelRem - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Monitor: record divider starts and score every returned result.
  always @(negedge clock) begin
    if (div_en) begin
      enCount++;
      enCyc = cyc;
      enSel = div_select;
    end
    if (valid0 || valid1) begin
      checkOutput("valid_excl", {127'd0, valid0 & valid1}, 128'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", {126'd0, valid1, valid0}, 128'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("grant", {127'd0, valid1}, {127'd0, e.sel});
        checkOutput("res", {102'd0, res}, {102'd0, e.res});
        checkOutput("err", {127'd0, err}, {127'd0, e.err});
        if (e.lat >= 0) begin
          checkOutput("latency", 128'(cyc - e.start), 128'(e.lat));
        end
      end
    end
  end

  task automatic pushExpect(input logic sel, input logic [WIDTH-1:0] r, input logic er, input int lat);
    exp_t x;
    x.sel = sel; x.res = r; x.err = er; x.start = cyc; x.lat = lat;
    sb.push_back(x);
  endtask

  // Drive one cycle of requests starting just after a rising edge.
  task automatic applyStimulus(input logic r0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic r1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    req0 = r0; dividend0 = a0; divisor0 = b0;
    req1 = r1; dividend1 = a1; divisor1 = b1;
    @(posedge clock);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clock);
    checkOutput("drain", 128'(sb.size()), 128'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset(input string tag, input int cycles);
    sb.delete();
    reset_n = 1'b0;
    repeat (cycles) @(posedge clock);
    @(negedge clock);
    checkOutput(tag, {43'd0, div_en, div_select, div_dividend, div_divisor, res, valid0, valid1, err, overrun}, 128'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    bit seen;

    doReset("reset_state", 2);

    // Single request: 1000/7, ready 26 cycles after start.
    modelDelay = 26;
    base = enCount;
    pushExpect(1'b0, 26'd142, 1'b0, 29);
    begin
      int t0;
      t0 = cyc;
      applyStimulus(1'b1, 26'd1000, 26'd7, 1'b0, '0, '0);
      waitDrain(100);
      checkOutput("single_div_en_cycle", 128'(enCyc - t0), 128'd2);
    end
    checkOutput("single_div_select", {127'd0, enSel}, 128'd0);
    checkOutput("single_div_en_count", 128'(enCount - base), 128'd1);

    // Divide-by-zero on requester 1: immediate error, divider untouched.
    base = enCount;
    pushExpect(1'b1, 26'h3FFFFFF, 1'b1, 2);
    applyStimulus(1'b0, '0, '0, 1'b1, 26'd55, 26'd0);
    waitDrain(20);
    checkOutput("dz_no_div_en", 128'(enCount - base), 128'd0);
    checkOutput("dz_res_hold", {101'd0, err, res}, {101'd0, 1'b1, 26'h3FFFFFF});

    // Timeout: divider never answers.
    modelHang = 1'b1;
    pushExpect(1'b0, 26'h3FFFFFF, 1'b1, 3 + TIMEOUT);
    applyStimulus(1'b1, 26'd100, 26'd5, 1'b0, '0, '0);
    waitDrain(200);
    modelHang = 1'b0;
    modelDelay = 4;
    pushExpect(1'b0, 26'd20, 1'b0, -1);
    applyStimulus(1'b1, 26'd100, 26'd5, 1'b0, '0, '0);
    waitDrain(100);

    // Round-robin after a fresh reset: 0 then 1, then after a lone req0 the tie goes to 1.
    doReset("reset_state_rr", 2);
    pushExpect(1'b0, 26'd10, 1'b0, -1);
    pushExpect(1'b1, 26'd10, 1'b0, -1);
    applyStimulus(1'b1, 26'd100, 26'd10, 1'b1, 26'd90, 26'd9);
    waitDrain(100);
    pushExpect(1'b0, 26'd7, 1'b0, -1);
    applyStimulus(1'b1, 26'd63, 26'd9, 1'b0, '0, '0);
    waitDrain(100);
    pushExpect(1'b1, 26'd12, 1'b0, -1);
    pushExpect(1'b0, 26'd11, 1'b0, -1);
    applyStimulus(1'b1, 26'd77, 26'd7, 1'b1, 26'd96, 26'd8);
    waitDrain(100);

    // Overrun: second req0 while pending is dropped; first operands are used.
    checkOutput("overrun_clear", {126'd0, overrun}, 128'd0);
    pushExpect(1'b0, 26'd100, 1'b0, -1);
    applyStimulus(1'b1, 26'd500, 26'd5, 1'b0, '0, '0);
    applyStimulus(1'b1, 26'd600, 26'd3, 1'b0, '0, '0);
    checkOutput("overrun_set", {126'd0, overrun}, 128'd1);

    // Re-request in the DONE cycle is accepted.
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (valid0) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", {127'd0, seen}, 128'd1);
    pushExpect(1'b0, 26'd21, 1'b0, -1);
    req0 = 1'b1; dividend0 = 26'd84; divisor0 = 26'd4;
    @(posedge clock);
    #1;
    req0 = 1'b0;
    waitDrain(100);
    checkOutput("overrun_hold", {126'd0, overrun}, 128'd1);

    // Reset in WAIT: outputs clear, the late divider ready is ignored.
    modelDelay = 26;
    applyStimulus(1'b1, 26'd200, 26'd4, 1'b0, '0, '0);
    repeat (8) @(posedge clock);
    #1;
    doReset("midwait_reset", 1);
    repeat (40) @(posedge clock);
    #1;
    checkOutput("stray_ready_res", {102'd0, res}, 128'd0);
    checkOutput("stray_ready_sb", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
